// File: rtl/shift_result_stage.sv
// shift_result_stage: 2-entry skid buffer capturing shifter results, committing Z and feeding EX->ID forwarding
module shift_result_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_mode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_en,
  output logic              out_err,
  output logic              flag_z,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);
  localparam int EW = DATA_W + REG_AW + 2;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  logic [1:0]    count_q, count_d;
  logic [EW-1:0] head_q, head_d, tail_q, tail_d, new_entry;
  logic          flag_z_q, flag_z_d;
  logic          push, pop, err_in, load_head, load_tail, shift;
  assign in_ready = ~rst & (count_q != FULL);
  assign out_valid = count_q != EMPTY;
  assign {out_result, out_rd, out_wr_en, out_err} = head_q;
  assign flag_z = flag_z_q;
  assign fwd_valid = out_valid & out_wr_en;
  assign fwd_rd = out_rd;
  assign fwd_data = out_result;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign err_in = in_mode == 2'b11;
  // illegal mode never writes the register file
  assign new_entry = {in_result, in_rd, in_wr_en & ~err_in, err_in};
  always_comb begin
    load_head = ~flush & push & ((count_q == EMPTY) | ((count_q == ONE) & pop));
    load_tail = ~flush & push & (count_q == ONE) & ~pop;
    shift = ~flush & pop & (count_q == FULL);
    count_d = flush ? EMPTY : count_q + {1'b0, push} - {1'b0, pop};
    head_d = load_head ? new_entry : shift ? tail_q : head_q;
    tail_d = load_tail ? new_entry : tail_q;
    flag_z_d = (~flush & pop & out_wr_en & ~out_err) ? (out_result == '0) : flag_z_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      flag_z_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
      flag_z_q <= flag_z_d;
    end
  end
endmodule

// File: tb/tb_shift_result_stage.sv
// tb_shift_result_stage: directed checks of the shift result skid buffer
module tb_shift_result_stage;
  logic        clk = 0, rst = 1, in_valid = 0, in_wr_en = 0, flush = 0, out_ready = 0;
  logic [15:0] in_result = 0;
  logic [1:0]  in_mode = 0;
  logic [3:0]  in_rd = 0;
  logic        in_ready, out_valid, out_wr_en, out_err, flag_z, fwd_valid;
  logic [15:0] out_result, fwd_data;
  logic [3:0]  out_rd, fwd_rd;
  int checks = 0, failures = 0;
  shift_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_mode(in_mode), .in_rd(in_rd), .in_wr_en(in_wr_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_err(out_err), .flag_z(flag_z), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] rd, input logic [1:0] m, input logic rdy);
    in_valid = v;
    in_result = r;
    in_rd = rd;
    in_mode = m;
    in_wr_en = 1;
    out_ready = rdy;
  endtask
  initial begin
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_fwd", {fwd_valid, fwd_rd, fwd_data}, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    // 1: zero result, rd=3
    drive(1, 16'h0000, 3, 0, 1);
    step();
    chk("t1_out", {out_valid, out_result, fwd_valid, fwd_rd}, {1'b1, 16'h0000, 1'b1, 4'd3});
    drive(0, 0, 0, 0, 1);
    step();
    chk("t1_flag_z", flag_z, 1);
    chk("t1_empty", out_valid, 0);
    // 2: fill with out_ready low
    drive(1, 16'h8001, 1, 0, 0);
    step();
    drive(1, 16'h00F0, 2, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_head", out_result, 16'h8001);
    step();
    chk("t2_head_hold", {out_valid, out_result, out_rd}, {1'b1, 16'h8001, 4'd1});
    out_ready = 1;
    step();
    chk("t2_second", {out_valid, out_result, out_rd}, {1'b1, 16'h00F0, 4'd2});
    chk("t2_flag_z_a", flag_z, 0);
    step();
    chk("t2_empty", out_valid, 0);
    chk("t2_flag_z_b", flag_z, 0);
    // 3: simultaneous push/pop in ONE
    drive(1, 16'h1234, 4, 1, 0);
    step();
    chk("t3_head", out_result, 16'h1234);
    drive(1, 16'h5678, 6, 2, 1);
    step();
    chk("t3_replaced", {out_valid, out_result, out_rd, in_ready}, {1'b1, 16'h5678, 4'd6, 1'b1});
    drive(0, 0, 0, 0, 0);
    step();
    chk("t3_still_one", {out_valid, out_result}, {1'b1, 16'h5678});
    out_ready = 1;
    step();
    chk("t3_empty", out_valid, 0);
    // 4: illegal mode with zero result
    drive(1, 16'h0000, 5, 3, 0);
    step();
    chk("t4_err", {out_valid, out_err, out_wr_en, fwd_valid}, 4'b1100);
    drive(0, 0, 0, 0, 1);
    step();
    chk("t4_flag_z", {out_valid, flag_z}, 2'b00);
    // 5: set flag_z, fill, flush
    drive(1, 16'h0000, 7, 0, 1);
    step();
    drive(0, 0, 0, 0, 1);
    step();
    chk("t5_flag_set", flag_z, 1);
    drive(1, 16'h0011, 8, 0, 0);
    step();
    drive(1, 16'h0022, 9, 0, 0);
    step();
    chk("t5_full", in_ready, 0);
    drive(1, 16'h0033, 10, 0, 1);
    flush = 1;
    step();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    chk("t5_flush", {out_valid, in_ready, flag_z}, 3'b011);
    step();
    chk("t5_dropped", out_valid, 0);
    // 6: reset in FULL
    drive(1, 16'hAAAA, 11, 0, 0);
    step();
    drive(1, 16'hBBBB, 12, 0, 0);
    step();
    chk("t6_full", in_ready, 0);
    drive(0, 0, 0, 0, 0);
    rst = 1;
    step();
    chk("t6_outs", {out_valid, out_result, out_rd, out_wr_en, out_err, flag_z}, 0);
    chk("t6_fwd", {fwd_valid, fwd_rd, fwd_data}, 0);
    chk("t6_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("t6_release", in_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
